ram_frame_reader: RTL
=====================

// Module: ram_frame_reader
// PURPOSE
//  Read side of the pixel frame RAM. The write controller (WR_CLOCK domain) asserts a frame-ready level
//  near the end of each frame. This block detects that level, reads the full frame out of the dual-port
//  RAM in raster order, and streams it downstream (USB/FIFO bridge) with valid/ready flow control.
//  It owns RD_EN/RD_ADDRESS of the RAM's read port. All logic runs in the RD_CLOCK domain.
// PARAMETERS
//  COLS        250    pixels per row
//  ROWS        250    rows per frame; COLS*ROWS <= 65536
//  RD_LATENCY  2      RAM clocks from RD_EN (address sampled) to valid RAM_Q
//  FIFO_DEPTH  4      output buffer entries; power of 2, >= RD_LATENCY+1
// PORTS
//  RD_CLOCK     in   1   read-side clock
//  RESET        in   1   asynchronous, active-low reset
//  FRAME_READY  in   1   frame-ready level from write side (WR_CLOCK domain, asynchronous here)
//  RD_EN        out  1   RAM read enable
//  RD_ADDRESS   out  16  RAM read address
//  RAM_Q        in   8   RAM read data, valid RD_LATENCY cycles after RD_EN
//  PIX_DATA     out  8   pixel to downstream
//  PIX_VALID    out  1   PIX_DATA/flags valid
//  PIX_READY    in   1   downstream accepts when PIX_VALID & PIX_READY
//  PIX_SOF      out  1   qualifies pixel 0 of frame
//  PIX_EOL      out  1   qualifies last pixel of each row (col == COLS-1)
//  PIX_EOF      out  1   qualifies pixel COLS*ROWS-1
//  BUSY         out  1   high in READ or DRAIN
//  FRAME_DONE   out  1   1-cycle pulse when the last pixel is accepted downstream
//  FRAME_DROP   out  1   1-cycle pulse when a frame-ready edge arrives while BUSY
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; FIFO empty; counters 0; synchroniser flops 0.
//  Input sync: FRAME_READY passes through a 2-flop synchroniser; start = rising edge of the synced value.
//   Edge-to-first-RD_EN latency is 4 RD_CLOCK cycles (2 sync, 1 edge, 1 state).
//  FSM:
//   IDLE  -> READ on start; rd_addr cleared to 0.
//   READ  issues one read per cycle while credit is available:
//         credit = (fifo_count + in_flight) < FIFO_DEPTH.
//         RD_EN = 1, RD_ADDRESS = rd_addr, and rd_addr increments on the same cycle.
//         The read of address COLS*ROWS-1 moves the FSM to DRAIN.
//   DRAIN -> IDLE when in_flight == 0 and the EOF pixel is accepted; FRAME_DONE pulses that cycle.
//  Read pipeline: an RD_LATENCY-deep valid shift register tracks in-flight reads.
//   When its tail is set, RAM_Q is written to the FIFO. The credit rule guarantees the FIFO never overflows.
//  Output: PIX_DATA is the FIFO head (first-word fall-through); PIX_VALID = !fifo_empty.
//   PIX_DATA and flags hold stable while PIX_VALID & !PIX_READY.
//   Simultaneous FIFO push and pop in one cycle is legal; count is unchanged.
//  Flags: out_col (0..COLS-1) and out_pix (0..COLS*ROWS-1) advance on each accepted pixel.
//   out_col wraps to 0 after COLS-1. Both clear on entry to READ.
//   SOF = (out_pix == 0); EOL = (out_col == COLS-1); EOF = (out_pix == COLS*ROWS-1).
//  RD_ADDRESS is 16 bits; rd_addr never exceeds COLS*ROWS-1 and does not wrap.
//   RD_ADDRESS holds its last value when RD_EN = 0.
//  Start while BUSY: the frame in progress continues, FRAME_DROP pulses, and the edge is not queued.
//  Start in the same cycle as the DRAIN->IDLE transition: counts as BUSY, so the edge is dropped.
//  RESET asserted mid-frame: immediate return to IDLE with the FIFO flushed and no FRAME_DONE.
//   After release, a FRAME_READY level that is already high does not start a read; a fresh rising edge is required.
// TESTING
//  1 Basic frame (COLS=4, ROWS=3, PIX_READY=1): FRAME_READY rises -> first RD_EN 4 cycles later;
//    addresses 0..11 read back-to-back; 12 pixels out with SOF on 0, EOL on 3/7/11, EOF on 11; FRAME_DONE once.
//  2 Backpressure: PIX_READY pattern 1,0,0,1 repeated -> no pixel lost or duplicated;
//    fifo_count + in_flight <= 4 at all times; data stable while stalled.
//  3 PIX_READY held 0 for 50 cycles mid-frame -> RD_EN stops after the FIFO fills;
//    on release, readout resumes at the next address.
//  4 Second FRAME_READY edge during READ -> FRAME_DROP pulses once; current frame completes intact;
//    no second readout starts.
//  5 RESET low at pixel 6 -> outputs 0 within the reset; with FRAME_READY held high after release there is no readout;
//    a low-then-high pulse starts a full frame from address 0.
//  6 Default params: 62500 pixels, last address 62499 = 16'hF423; EOF only on the final pixel;
//    EOL count = 250.

Source files
------------

// File: rtl/ram_frame_reader_if.sv
//------------------------------------------------------------------------------
// Module      : ram_frame_reader_if
// Description : RAM read port plus pixel stream bundle for the frame reader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ram_frame_reader_if;
  logic        RD_EN;
  logic [15:0] RD_ADDRESS;
  logic [7:0]  RAM_Q;
  logic [7:0]  PIX_DATA;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic        PIX_SOF;
  logic        PIX_EOL;
  logic        PIX_EOF;

  modport master (
    output RD_EN, RD_ADDRESS, PIX_DATA, PIX_VALID, PIX_SOF, PIX_EOL, PIX_EOF,
    input  RAM_Q, PIX_READY
  );

  modport slave (
    input  RD_EN, RD_ADDRESS, PIX_DATA, PIX_VALID, PIX_SOF, PIX_EOL, PIX_EOF,
    output RAM_Q, PIX_READY
  );
endinterface

`default_nettype wire

// File: rtl/ram_frame_reader.sv
//------------------------------------------------------------------------------
// Module      : ram_frame_reader
// Description : Reads a full frame from the pixel RAM on a frame-ready edge and
//               streams it downstream with valid/ready flow control.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_frame_reader #(
  parameter int COLS       = 250,
  parameter int ROWS       = 250,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               RD_CLOCK,
  input  logic               RESET,
  input  logic               FRAME_READY,
  ram_frame_reader_if.master bus,
  output logic               BUSY,
  output logic               FRAME_DONE,
  output logic               FRAME_DROP
);

  localparam int              c_NPIX      = COLS * ROWS;
  localparam logic [15:0]     c_LAST_ADDR = 16'(c_NPIX - 1);
  localparam logic [15:0]     c_LAST_COL  = 16'(COLS - 1);
  localparam int              c_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              c_CNT_W     = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_sync_d;
  logic [1:0]        r_sync_vld;
  logic              r_armed;
  logic              r_start;

  logic [15:0]       r_rd_addr;
  logic [15:0]       r_out_col;
  logic [15:0]       r_out_pix;

  logic [RD_LATENCY-1:0] r_pipe;
  logic [c_CNT_W-1:0]    r_in_flight;
  logic [c_CNT_W-1:0]    r_fifo_count;
  logic [c_PTR_W-1:0]    r_wptr;
  logic [c_PTR_W-1:0]    r_rptr;
  logic [7:0]            r_fifo_mem [FIFO_DEPTH];

  logic              w_rd_en;
  logic              w_frame_done;
  logic              w_frame_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_valid;
  logic              w_credit;
  logic              w_out_eof;
  logic              w_enter_read;

  // The synchroniser's reset value is not a real sample of FRAME_READY, so a
  // start is only armed once a genuine low level has been seen after reset.
  always_ff @(posedge RD_CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync_d   <= 1'b0;
      r_sync_vld <= 2'b00;
      r_armed    <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      r_sync1    <= FRAME_READY;
      r_sync2    <= r_sync1;
      r_sync_d   <= r_sync2;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      if (r_sync_vld[1] && !r_sync2) begin
        r_armed <= 1'b1;
      end
      r_start    <= r_armed && r_sync2 && !r_sync_d;
    end
  end

  assign w_push       = r_pipe[RD_LATENCY-1];
  assign w_fifo_valid = (r_fifo_count != '0);
  assign w_pop        = w_fifo_valid && bus.PIX_READY;
  assign w_credit     = (r_fifo_count + r_in_flight) < c_DEPTH;
  assign w_out_eof    = (r_out_pix == c_LAST_ADDR);
  assign w_enter_read = (r_state == ST_IDLE) && r_start;

  always_ff @(posedge RD_CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_frame_done = 1'b0;
    w_frame_drop = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_start) begin
          w_state_next = ST_READ;
        end
      end
      ST_READ: begin
        w_frame_drop = r_start;
        if (w_credit) begin
          w_rd_en = 1'b1;
          if (r_rd_addr == c_LAST_ADDR) begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        w_frame_drop = r_start;
        if ((r_in_flight == '0) && w_pop && w_out_eof) begin
          w_frame_done = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Address, output position and read-pipeline bookkeeping.
  always_ff @(posedge RD_CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_rd_addr    <= '0;
      r_out_col    <= '0;
      r_out_pix    <= '0;
      r_pipe       <= '0;
      r_in_flight  <= '0;
      r_fifo_count <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
    end else begin
      if (w_enter_read) begin
        r_rd_addr <= '0;
      end else if (w_rd_en && (r_rd_addr != c_LAST_ADDR)) begin
        r_rd_addr <= r_rd_addr + 16'd1;
      end

      if (w_enter_read) begin
        r_out_col <= '0;
        r_out_pix <= '0;
      end else if (w_pop) begin
        r_out_col <= (r_out_col == c_LAST_COL) ? 16'd0 : r_out_col + 16'd1;
        if (!w_out_eof) begin
          r_out_pix <= r_out_pix + 16'd1;
        end
      end

      r_pipe      <= (r_pipe << 1) | RD_LATENCY'(w_rd_en);
      r_in_flight <= r_in_flight + (w_rd_en ? c_ONE : '0) - (w_push ? c_ONE : '0);

      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      r_fifo_count <= r_fifo_count + (w_push ? c_ONE : '0) - (w_pop ? c_ONE : '0);
    end
  end

  always_ff @(posedge RD_CLOCK) begin
    if (w_push) begin
      r_fifo_mem[r_wptr] <= bus.RAM_Q;
    end
  end

  assign bus.RD_EN      = w_rd_en;
  assign bus.RD_ADDRESS = r_rd_addr;
  assign bus.PIX_VALID  = w_fifo_valid;
  assign bus.PIX_DATA   = w_fifo_valid ? r_fifo_mem[r_rptr] : 8'd0;
  assign bus.PIX_SOF    = w_fifo_valid && (r_out_pix == 16'd0);
  assign bus.PIX_EOL    = w_fifo_valid && (r_out_col == c_LAST_COL);
  assign bus.PIX_EOF    = w_fifo_valid && w_out_eof;

  assign BUSY       = (r_state != ST_IDLE);
  assign FRAME_DONE = w_frame_done;
  assign FRAME_DROP = w_frame_drop;

endmodule

`default_nettype wire
